// File: rtl/fix_pkg.sv
// Shared widths, state encoding and saturation words for the Q31/Q15 divider.
package fix_pkg;

    localparam int Q15_W = 16;
    localparam int Q31_W = 32;
    localparam int ITER  = 15;
    localparam int CNT_W = 4;
    localparam int DIV_W = Q15_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } fix_state_e;

    localparam logic [Q15_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [Q15_W-1:0] SAT_NEG = 16'h8001;

    // Symmetric saturation: the most negative code 0x8000 is never produced.
    function automatic logic [Q15_W-1:0] sat_word(input logic neg);
        return neg ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/fix_abs.sv
// Two's-complement to sign + unsigned magnitude; the most negative code maps to 2^(W-1).
module fix_abs #(
    parameter int W = 16
) (
    input  logic [W-1:0] val,
    output logic         neg,
    output logic [W-1:0] mag
);

    always_comb begin
        neg = val[W-1];
        mag = val[W-1] ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;
    end

endmodule

// File: rtl/fix_div.sv
// Restoring sign-magnitude divider, Q31 / Q15 -> Q15, fixed 18-cycle throughput.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured when it is seen
//   LOAD  | magnitudes, sign, divide-by-zero and overflow flags formed
//   CALC  | one restoring step per cycle, quotient bit 14 down to 0
//   FIN   | result (or saturated word) registered, out_valid pulsed
module fix_div
    import fix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Q31_W-1:0] in_a,
    input  logic [Q15_W-1:0] in_b,
    output logic             busy,
    output logic             out_valid,
    output logic [Q15_W-1:0] q_out,
    output logic             ovf,
    output logic             dz
);

    fix_state_e state;
    fix_state_e state_nxt;

    logic [Q31_W-1:0] a_reg;
    logic [Q15_W-1:0] b_reg;
    logic [Q31_W-1:0] r_reg;
    logic [DIV_W-1:0] d_reg;
    logic [ITER-1:0]  qm_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             sign_reg;
    logic             a_neg_reg;
    logic             dz_f;
    logic             ovf_f;

    logic             a_neg;
    logic             b_neg;
    logic [Q31_W-1:0] a_mag;
    logic [Q15_W-1:0] b_mag;
    logic [Q31_W-1:0] d_shift;
    logic [Q15_W-1:0] q_mag;

    fix_abs #(.W(Q31_W)) u_abs_a (
        .val (a_reg),
        .neg (a_neg),
        .mag (a_mag)
    );

    fix_abs #(.W(Q15_W)) u_abs_b (
        .val (b_reg),
        .neg (b_neg),
        .mag (b_mag)
    );

    // Without overflow R < D<<15, so a 32-bit remainder never truncates.
    assign d_shift = {{(Q31_W-DIV_W){1'b0}}, d_reg} << cnt_reg;
    assign q_mag   = {1'b0, qm_reg};
    assign busy    = (state != IDLE);

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = CALC;
            CALC: if (cnt_reg == '0) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            qm_reg    <= '0;
            cnt_reg   <= '0;
            sign_reg  <= 1'b0;
            a_neg_reg <= 1'b0;
            dz_f      <= 1'b0;
            ovf_f     <= 1'b0;
            out_valid <= 1'b0;
            q_out     <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                    end
                end
                LOAD: begin
                    r_reg     <= a_mag;
                    d_reg     <= {b_mag, 1'b0};
                    sign_reg  <= a_neg ^ b_neg;
                    a_neg_reg <= a_neg;
                    dz_f      <= (b_mag == '0);
                    ovf_f     <= (b_mag != '0) && (a_mag >= {b_mag, 16'b0});
                    qm_reg    <= '0;
                    cnt_reg   <= CNT_W'(ITER - 1);
                end
                CALC: begin
                    // Steps run even for dz/ovf so the latency never varies.
                    if (r_reg >= d_shift) begin
                        r_reg  <= r_reg - d_shift;
                        qm_reg <= {qm_reg[ITER-2:0], 1'b1};
                    end else begin
                        qm_reg <= {qm_reg[ITER-2:0], 1'b0};
                    end
                    if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_W'(1);
                end
                FIN: begin
                    out_valid <= 1'b1;
                    if (dz_f) begin
                        q_out <= sat_word(a_neg_reg);
                        dz    <= 1'b1;
                        ovf   <= 1'b0;
                    end else if (ovf_f) begin
                        q_out <= sat_word(sign_reg);
                        dz    <= 1'b0;
                        ovf   <= 1'b1;
                    end else begin
                        q_out <= sign_reg ? (~q_mag + 16'd1) : q_mag;
                        dz    <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fix_div.sv
// Scoreboard bench for fix_div: directed vectors, handshake, reset abort, random ops.
module tb_fix_div;

    typedef struct {
        logic [15:0] q;
        logic        ovf;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] in_a;
    logic [15:0] in_b;
    logic        busy;
    logic        out_valid;
    logic [15:0] q_out;
    logic        ovf;
    logic        dz;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb_q[$];

    fix_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_a      (in_a),
        .in_b      (in_b),
        .busy      (busy),
        .out_valid (out_valid),
        .q_out     (q_out),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
        exp_t   e;
        longint sa, sbv, am, bm, qm;
        bit     neg;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        am  = (sa < 0) ? -sa : sa;
        bm  = (sbv < 0) ? -sbv : sbv;
        neg = (sa < 0) != (sbv < 0);
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        if (bm == 0) begin
            e.q  = (sa < 0) ? 16'h8001 : 16'h7FFF;
            e.dz = 1'b1;
        end else if (am >= bm * 65536) begin
            e.q   = neg ? 16'h8001 : 16'h7FFF;
            e.ovf = 1'b1;
        end else begin
            qm  = am / (2 * bm);
            e.q = neg ? 16'(-qm) : 16'(qm);
        end
        return e;
    endfunction

    // Result checker: every out_valid pulse must match the oldest outstanding request.
    always @(posedge clk) begin
        if (out_valid === 1'b1) begin
            chk("valid_has_request", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("q_out", 32'(q_out), 32'(e.q));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("dz", 32'(dz), 32'(e.dz));
            end
        end
    end

    // Called at a rising edge; returns at the rising edge where out_valid is seen.
    task automatic do_op(input logic [31:0] a, input logic [15:0] b, input bit chk_busy);
        int j;
        bit done;
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        sb_q.push_back(model(a, b));
        @(negedge clk);
        j = 0;
        done = 0;
        while (!done && j < 40) begin
            @(posedge clk);
            if (j == 0) start = 1'b0;
            if (chk_busy && j >= 1 && j <= 16) chk("busy_high", 32'(busy), 32'd1);
            if (out_valid === 1'b1) done = 1;
            else j++;
        end
        chk("latency", 32'(j), 32'd17);
        if (chk_busy) chk("busy_low_at_valid", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [15:0] rb;
        int          j;
        int          nv;
        exp_t        e;

        rst_n = 1'b0;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(q_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);

        // Basic op with busy and single-pulse checks, then hold check.
        do_op(32'h2000_0000, 16'h4000, 1'b1);
        @(posedge clk);
        chk("valid_single", 32'(out_valid), 32'd0);
        chk("q_held", 32'(q_out), 32'h4000);

        do_op(32'hE000_0000, 16'h4000, 1'b0); @(posedge clk);
        do_op(32'h0000_0003, 16'h0001, 1'b0); @(posedge clk);
        do_op(32'hFFFF_FFFD, 16'h0001, 1'b0); @(posedge clk);
        do_op(32'h0000_0001, 16'h0001, 1'b0); @(posedge clk);
        do_op(32'h4000_0000, 16'h2000, 1'b0); @(posedge clk);
        do_op(32'h8000_0000, 16'h8000, 1'b0); @(posedge clk);
        do_op(32'h8000_0000, 16'h7FFF, 1'b0); @(posedge clk);
        do_op(32'hC000_0000, 16'h0000, 1'b1); @(posedge clk);
        do_op(32'h3FFF_FFFF, 16'h4000, 1'b0); @(posedge clk);
        do_op(32'hC000_0001, 16'hC000, 1'b0); @(posedge clk);

        // Start while busy is ignored; next start right after completion is taken.
        in_a  = 32'h1000_0000;
        in_b  = 16'h2000;
        start = 1'b1;
        sb_q.push_back(model(32'h1000_0000, 16'h2000));
        @(negedge clk);
        j  = 0;
        nv = 0;
        while (nv == 0 && j < 40) begin
            @(posedge clk);
            if (j == 0) start = 1'b0;
            if (j == 4) begin
                in_a  = 32'hF000_0000;
                in_b  = 16'h0100;
                start = 1'b1;
            end
            if (j == 5) start = 1'b0;
            if (out_valid === 1'b1) nv = 1;
            else j++;
        end
        chk("hs_latency", 32'(j), 32'd17);
        do_op(32'hF000_0000, 16'h7000, 1'b0);
        @(posedge clk);
        chk("hs_valid_single", 32'(out_valid), 32'd0);

        // Reset in the middle of an operation aborts it silently.
        in_a  = 32'h2000_0000;
        in_b  = 16'hC000;
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            if (k == 0) start = 1'b0;
            if (k == 7) rst_n = 1'b0;
        end
        @(posedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_q", 32'(q_out), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (out_valid === 1'b1) nv++;
        end
        chk("abort_no_valid", 32'(nv), 32'd0);
        do_op(32'h2000_0000, 16'hC000, 1'b1); @(posedge clk);

        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            ra = 32'($signed(ra) >>> $urandom_range(0, 18));
            rb = 16'($urandom_range(0, 65535));
            do_op(ra, rb, 1'b0);
            @(posedge clk);
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
